tone_packetizer: RTL
====================

# tone_packetizer

Downstream framing stage for the sine-tone generator: consumes its continuous 32-bit IQ AXI-stream and emits packets of a programmable samples-per-packet (SPP) length with `o_tlast` on the final sample. It supports continuous or fixed-length burst operation under settings-bus control, sitting between `sine_tone` and the RFNoC chdr framer.

## Interface
Parameters:
- `WIDTH`, 32: sample width (I in [15:0], Q in [31:16]).
- `SR_SPP`, 131: settings address of SPP register.
- `SR_BURST`, 132: settings address of burst length in packets.
- `SR_CTRL`, 133: settings address of control strobe register.
- `SPP_W`, 16: SPP counter width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous soft clear.
- `set_stb`  in  1  settings write strobe.
- `set_addr`  in  8  settings address.
- `set_data`  in  32  settings data.
- `i_tdata`  in  WIDTH  input samples.
- `i_tlast`  in  1  ignored.
- `i_tvalid`  in  1  input valid.
- `i_tready`  out  1  input ready.
- `o_tdata`  out  WIDTH  output samples.
- `o_tlast`  out  1  last sample of packet.
- `o_tvalid`  out  1  output valid.
- `o_tready`  in  1  output ready.
- `burst_done`  out  1  one-cycle pulse when a burst completes.
- `pkt_count`  out  32  packets emitted since reset/clear, wraps.

## Operation
- Registers: `spp` (SPP_W bits, reset 16; write of 0 stored as 1), `burst_len` (32 bits, reset 0 = continuous).
- CTRL write: bit0 = start, bit1 = stop. Both set in one write: stop wins. Other bits ignored.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: `i_tready`=0, stalling the upstream.
  - IDLE -> RUN on start. Clears packet counter and burst counter.
  - RUN: samples pass through. Sample counter increments on each input handshake. The sample at count `spp_latched-1` is tagged tlast and the counter resets.
  - RUN -> STOPPING on stop mid-packet. RUN -> IDLE on stop at a packet boundary (counter = 0).
  - STOPPING: the current packet completes, then IDLE.
  - Burst mode (`burst_len` != 0): after `burst_len` tagged tlasts, go to IDLE and pulse `burst_done` in the cycle after the final input handshake.
  - Start in RUN/STOPPING is ignored.
- `spp` is latched into `spp_latched` only at the start of a packet (counter = 0 on a handshake, or on entry to RUN). A mid-packet SPP write applies to the next packet.
- `pkt_count` increments on each output handshake with `o_tlast`=1. 32-bit wrap.
- `clear`: FSM to IDLE, skid buffer flushed, counters and `pkt_count` zeroed, config registers retained.
- `reset_n` low: all state to reset values immediately. Outputs `o_tvalid`, `o_tlast`, `i_tready`, `burst_done` = 0. `o_tdata` = 0. `pkt_count` = 0.

## Timing
- Settings write visible to the FSM the cycle after `set_stb`. First possible input handshake is 1 cycle after the start strobe.
- Data latency input -> output is 1 cycle. Full throughput: 1 sample/cycle with `o_tready` held high.
- `i_tready` is registered (skid buffer, 2 entries). Backpressure on `o_tready` never drops or duplicates samples.
- `o_tvalid` never deasserts without a handshake, and `o_tdata`/`o_tlast` are stable while stalled (AXI rules).
- The input handshake that tags the final burst tlast is the last accepted. `i_tready` = 0 from the next cycle.
- Simultaneous final-sample handshake and stop: the packet is complete, so the block goes directly to IDLE with no extra packet.

## Structure
- Package `tone_packetizer_pkg`:
  - state enum `{IDLE, RUN, STOPPING}`;
  - default SR addresses;
  - CTRL bit positions;
  - default SPP = 16.
- Sub-module `axis_skid_buffer` (WIDTH+1 data bits, registered ready, 2 entries), async active-low reset.
- Top contains the settings decode, FSM, counters and `pkt_count`.

## Test plan
- Reset/config: hold `reset_n` low mid-stream -> all outputs 0 immediately; after release `spp`=16 and IDLE, with `i_tready`=0.
- Continuous: `spp`=100, `burst_len`=0, start, ramp input, `o_tready`=1 for 1000 cycles -> tlast on samples 99, 199, …; data order intact; `pkt_count` = 10.
- Burst: `spp`=8, `burst_len`=3, start -> exactly 24 samples out, tlast on 7/15/23; `burst_done` pulses once; `i_tready` low afterwards.
- Backpressure: random 50% `o_tready`, `spp`=5, 200 samples -> no loss or duplication; tlast every 5th sample; data stable while stalled.
- Mid-packet stop and SPP change: `spp`=10, stop at sample 4 -> packet completes at sample 9 then IDLE. SPP write to 3 at sample 6 -> current packet stays 10, next packet 3.
- Edge cases:
  - `spp`=0 written -> packets of 1, tlast on every sample.
  - start+stop in one write -> stays IDLE.
  - `clear` mid-packet -> IDLE, `pkt_count`=0, `spp` retained.

Source files
------------

// File: rtl/tone_packetizer_pkg.sv
// Shared definitions for the tone packetizer: FSM states, default settings
// addresses, control bit positions and the default packet length.
package tone_packetizer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int unsigned SR_SPP_ADDR   = 131;
  localparam int unsigned SR_BURST_ADDR = 132;
  localparam int unsigned SR_CTRL_ADDR  = 133;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_STOP_BIT  = 1;

  localparam int unsigned DEFAULT_SPP = 16;

endpackage

// File: rtl/tone_packetizer_skid.sv
// Two-entry AXI-stream skid buffer. The ready seen upstream comes straight
// from a flop (skid slot empty), so the upstream path is cut; the output
// register gives one cycle of latency at full throughput.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             out_valid_r;
  logic             skid_valid_r;
  logic             in_fire_s;

  assign in_ready  = ~skid_valid_r;
  assign in_fire_s = in_valid & ~skid_valid_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

  // Move data through the output register, parking one word in the skid slot on a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_r   <= '0;
      skid_data_r  <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (clear) begin
      out_data_r   <= '0;
      skid_data_r  <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (!out_valid_r || out_ready) begin
      if (skid_valid_r) begin
        out_data_r   <= skid_data_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (in_fire_s) begin
        out_data_r  <= in_data;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (in_fire_s) begin
      skid_data_r  <= in_data;
      skid_valid_r <= 1'b1;
    end
  end

endmodule

// File: rtl/tone_packetizer.sv
// Frames the continuous IQ sample stream into packets of a programmable
// length, with continuous or fixed-burst operation under settings-bus control.
module tone_packetizer
  import tone_packetizer_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SR_SPP   = SR_SPP_ADDR,
  parameter int unsigned SR_BURST = SR_BURST_ADDR,
  parameter int unsigned SR_CTRL  = SR_CTRL_ADDR,
  parameter int unsigned SPP_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             burst_done,
  output logic [31:0]      pkt_count
);

  state_t           state_r;
  state_t           state_next_s;
  logic             enter_run_s;

  logic [SPP_W-1:0] spp_r;
  logic [SPP_W-1:0] spp_latched_r;
  logic [SPP_W-1:0] sample_cnt_r;
  logic [SPP_W-1:0] spp_eff_s;
  logic [SPP_W-1:0] spp_wr_val_s;
  logic [31:0]      burst_len_r;
  logic [31:0]      burst_cnt_r;
  logic [31:0]      pkt_count_r;
  logic             burst_done_r;

  logic             spp_wr_s;
  logic             burst_wr_s;
  logic             ctrl_wr_s;
  logic             start_s;
  logic             stop_s;
  logic             in_fire_s;
  logic             tag_last_s;
  logic             pkt_end_s;
  logic             burst_final_s;

  logic             skid_in_ready_s;
  logic [WIDTH:0]   skid_out_data_s;
  logic             skid_out_valid_s;

  // The incoming tlast is meaningless here; packet boundaries are regenerated.
  logic             unused_s;
  assign unused_s = i_tlast;

  // Settings decode; a start together with a stop is treated as a stop.
  assign spp_wr_s   = set_stb && (set_addr == 8'(SR_SPP));
  assign burst_wr_s = set_stb && (set_addr == 8'(SR_BURST));
  assign ctrl_wr_s  = set_stb && (set_addr == 8'(SR_CTRL));
  assign stop_s     = ctrl_wr_s && set_data[CTRL_STOP_BIT];
  assign start_s    = ctrl_wr_s && set_data[CTRL_START_BIT] && !set_data[CTRL_STOP_BIT];

  // A zero packet length is meaningless, so it is stored as one.
  assign spp_wr_val_s = (set_data[SPP_W-1:0] == '0) ? SPP_W'(1) : set_data[SPP_W-1:0];

  // Upstream is stalled in IDLE; otherwise ready follows the skid slot.
  assign i_tready  = skid_in_ready_s && (state_r != IDLE);
  assign in_fire_s = i_tvalid && i_tready;

  // The first sample of a packet picks up the current SPP; later samples use the latched copy.
  assign spp_eff_s     = (sample_cnt_r == '0) ? spp_r : spp_latched_r;
  assign tag_last_s    = ((sample_cnt_r + SPP_W'(1)) == spp_eff_s);
  assign pkt_end_s     = in_fire_s && tag_last_s;
  assign burst_final_s = pkt_end_s && (burst_len_r != 32'd0) &&
                         ((burst_cnt_r + 32'd1) == burst_len_r);

  // Configuration registers; they survive a soft clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spp_r       <= SPP_W'(DEFAULT_SPP);
      burst_len_r <= 32'd0;
    end else begin
      if (spp_wr_s) begin
        spp_r <= spp_wr_val_s;
      end
      if (burst_wr_s) begin
        burst_len_r <= set_data;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else if (clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: a stop lands in IDLE directly whenever no packet is left open.
  always_comb begin
    state_next_s = state_r;
    enter_run_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_next_s = RUN;
          enter_run_s  = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (burst_final_s) begin
          state_next_s = IDLE;
        end else if (stop_s) begin
          if (pkt_end_s || ((sample_cnt_r == '0) && !in_fire_s)) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = STOPPING;
          end
        end else begin
          state_next_s = RUN;
        end
      end
      STOPPING: begin
        if (pkt_end_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOPPING;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Sample, burst counters and the SPP latch; burst_done fires the cycle after the final handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt_r  <= '0;
      spp_latched_r <= SPP_W'(DEFAULT_SPP);
      burst_cnt_r   <= 32'd0;
      burst_done_r  <= 1'b0;
    end else if (clear) begin
      sample_cnt_r <= '0;
      burst_cnt_r  <= 32'd0;
      burst_done_r <= 1'b0;
    end else begin
      burst_done_r <= burst_final_s;
      if (enter_run_s) begin
        sample_cnt_r  <= '0;
        burst_cnt_r   <= 32'd0;
        spp_latched_r <= spp_r;
      end else if (in_fire_s) begin
        if (sample_cnt_r == '0) begin
          spp_latched_r <= spp_r;
        end
        if (tag_last_s) begin
          sample_cnt_r <= '0;
          burst_cnt_r  <= burst_cnt_r + 32'd1;
        end else begin
          sample_cnt_r <= sample_cnt_r + SPP_W'(1);
        end
      end
    end
  end

  // Packets that actually left the block, counted at the output tlast handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_r <= 32'd0;
    end else if (clear || enter_run_s) begin
      pkt_count_r <= 32'd0;
    end else if (o_tvalid && o_tready && o_tlast) begin
      pkt_count_r <= pkt_count_r + 32'd1;
    end
  end

  axis_skid_buffer #(
    .WIDTH(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_data  ({tag_last_s, i_tdata}),
    .in_valid (in_fire_s),
    .in_ready (skid_in_ready_s),
    .out_data (skid_out_data_s),
    .out_valid(skid_out_valid_s),
    .out_ready(o_tready)
  );

  assign o_tdata    = skid_out_data_s[WIDTH-1:0];
  assign o_tlast    = skid_out_data_s[WIDTH];
  assign o_tvalid   = skid_out_valid_s;
  assign burst_done = burst_done_r;
  assign pkt_count  = pkt_count_r;

endmodule
